// File: rtl/gmem_fill_if.sv
// Command and gmem write-port bundle for the rectangle fill engine.
// master: command source / gmem side; slave: the fill engine.
interface gmem_fill_if #(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned COLOR_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [8:0]         cmd_x0;
    logic [7:0]         cmd_y0;
    logic [8:0]         cmd_w;
    logic [7:0]         cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic               abort;
    logic               gmem_we;
    logic [ADDR_W-1:0]  gmem_waddr;
    logic [COLOR_W-1:0] gmem_wdat;
    logic               gmem_wready;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, abort, gmem_wready,
        input  cmd_ready, gmem_we, gmem_waddr, gmem_wdat, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, abort, gmem_wready,
        output cmd_ready, gmem_we, gmem_waddr, gmem_wdat, busy, done, err
    );
endinterface

// File: rtl/gmem_fill.sv
// Solid-colour rectangle fill into the 320x240 framebuffer: clips the command to the
// screen, then writes one pixel per accepted gmem cycle in row-major order.
module gmem_fill #(
    parameter int unsigned FB_W    = 320,
    parameter int unsigned FB_H    = 240,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned COLOR_W = 8
) (
    input logic        clk,
    input logic        rst,
    gmem_fill_if.slave bus
);

    localparam logic [9:0]        FbW10   = 10'(FB_W);
    localparam logic [9:0]        FbH10   = 10'(FB_H);
    localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(FB_W);

    typedef enum logic [1:0] {StIdle, StClip, StRun} state_e;

    state_e             state_q, state_d;
    logic [8:0]         x0_q, x0_d;
    logic [8:0]         w_q, w_d;
    logic [7:0]         h_q, h_d;
    logic [8:0]         x_q, x_d;
    logic [7:0]         y_q, y_d;
    logic [9:0]         x_end_q, x_end_d;
    logic [9:0]         y_end_q, y_end_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [COLOR_W-1:0] wdat_q, wdat_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [9:0]         sum_x, sum_y, x_nxt, y_nxt;
    logic [ADDR_W-1:0]  row_base_c;
    logic               clip_bad;

    // Ten-bit sums so x0+w and y0+h never wrap before clipping.
    assign sum_x      = {1'b0, x0_q} + {1'b0, w_q};
    assign sum_y      = {2'b00, y_q} + {2'b00, h_q};
    assign x_nxt      = {1'b0, x_q} + 10'd1;
    assign y_nxt      = {2'b00, y_q} + 10'd1;
    assign row_base_c = (ADDR_W'(y_q) << 8) + (ADDR_W'(y_q) << 6);
    assign clip_bad   = ({1'b0, x0_q} >= FbW10) || ({2'b00, y_q} >= FbH10) ||
                        (w_q == 9'd0) || (h_q == 8'd0);

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        w_d        = w_q;
        h_d        = h_q;
        x_d        = x_q;
        y_d        = y_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;
        color_d    = color_q;
        we_d       = we_q;
        waddr_d    = waddr_q;
        wdat_d     = wdat_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    state_d = StClip;
                    x0_d    = bus.cmd_x0;
                    y_d     = bus.cmd_y0;
                    w_d     = bus.cmd_w;
                    h_d     = bus.cmd_h;
                    color_d = bus.cmd_color;
                end
            end
            StClip: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (clip_bad) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    x_end_d    = (sum_x > FbW10) ? FbW10 : sum_x;
                    y_end_d    = (sum_y > FbH10) ? FbH10 : sum_y;
                    row_base_d = row_base_c;
                    x_d        = x0_q;
                    we_d       = 1'b1;
                    waddr_d    = row_base_c + ADDR_W'(x0_q);
                    wdat_d     = color_q;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    we_d    = 1'b0;
                    state_d = StIdle;
                end else if (bus.gmem_wready) begin
                    if (x_nxt < x_end_q) begin
                        x_d     = x_q + 9'd1;
                        waddr_d = row_base_q + ADDR_W'(x_nxt);
                    end else if (y_nxt < y_end_q) begin
                        // Row wrap folds straight into the next address: no bubble.
                        x_d        = x0_q;
                        y_d        = y_q + 8'd1;
                        row_base_d = row_base_q + RowStep;
                        waddr_d    = row_base_q + RowStep + ADDR_W'(x0_q);
                    end else begin
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                we_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            x0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
            color_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdat_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
            color_q    <= color_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdat_q     <= wdat_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q == StClip) || (state_q == StRun);
    assign bus.gmem_we    = we_q;
    assign bus.gmem_waddr = waddr_q;
    assign bus.gmem_wdat  = wdat_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_gmem_fill.sv
// Directed bench for gmem_fill: a negedge monitor logs writes and pulses, the main
// sequence issues commands and compares against hand-computed addresses and timings.
module tb_gmem_fill;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gmem_fill_if #(.ADDR_W(17), .COLOR_W(8)) bus ();

    gmem_fill #(
        .FB_W   (320),
        .FB_H   (240),
        .ADDR_W (17),
        .COLOR_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          cyc_n       = 0;
    int          wr_addr[$];
    int          wr_dat[$];
    int          we_cnt      = 0;
    int          done_cnt    = 0;
    int          err_cnt     = 0;
    int          accept_cyc  = 0;
    int          done_cyc    = 0;
    int          err_cyc     = 0;
    int          last_wr_cyc = 0;
    int          stall_err   = 0;
    logic        prev_stall  = 1'b0;
    logic [16:0] prev_addr   = '0;
    logic [7:0]  prev_dat    = '0;

    always @(negedge clk) begin
        if (bus.gmem_we === 1'b1) we_cnt++;
        if (bus.gmem_we === 1'b1 && bus.gmem_wready) begin
            wr_addr.push_back(int'(bus.gmem_waddr));
            wr_dat.push_back(int'(bus.gmem_wdat));
            last_wr_cyc = cyc_n;
        end
        if (prev_stall && (bus.gmem_we !== 1'b1 || bus.gmem_waddr !== prev_addr ||
                           bus.gmem_wdat !== prev_dat))
            stall_err++;
        prev_stall = (bus.gmem_we === 1'b1) && !bus.gmem_wready;
        prev_addr  = bus.gmem_waddr;
        prev_dat   = bus.gmem_wdat;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (bus.err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc_n;
        end
        if (bus.cmd_valid && bus.cmd_ready === 1'b1) accept_cyc = cyc_n;
        cyc_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic send(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] w,
                        input logic [7:0] h, input logic [7:0] c);
        check("send_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_x0    = x0;
        bus.cmd_y0    = y0;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outs(input string pfx);
        check({pfx, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({pfx, "_we"}, 32'(bus.gmem_we), 32'd0);
        check({pfx, "_waddr"}, 32'(bus.gmem_waddr), 32'd0);
        check({pfx, "_wdat"}, 32'(bus.gmem_wdat), 32'd0);
        check({pfx, "_busy"}, 32'(bus.busy), 32'd0);
        check({pfx, "_done"}, 32'(bus.done), 32'd0);
        check({pfx, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        int base, d0, e0, w0, bad;
        int exp1[8];
        int exp2[4];
        bit [0:5] bp;

        bus.cmd_valid   = 1'b0;
        bus.cmd_x0      = '0;
        bus.cmd_y0      = '0;
        bus.cmd_w       = '0;
        bus.cmd_h       = '0;
        bus.cmd_color   = '0;
        bus.abort       = 1'b0;
        bus.gmem_wready = 1'b1;

        rst = 1'b1;
        run(3);
        check_reset_outs("reset");
        rst = 1'b0;
        cyc();

        // Basic 4x2 fill
        exp1 = '{1610, 1611, 1612, 1613, 1930, 1931, 1932, 1933};
        base = wr_addr.size(); d0 = done_cnt; w0 = we_cnt;
        send(9'd10, 8'd5, 9'd4, 8'd2, 8'hE0);
        run(12);
        check("t1_nwr", 32'(wr_addr.size() - base), 32'd8);
        for (int i = 0; i < 8; i++)
            if (base + i < wr_addr.size()) check("t1_addr", 32'(wr_addr[base+i]), 32'(exp1[i]));
        bad = 0;
        for (int i = base; i < wr_dat.size(); i++) if (wr_dat[i] != 'hE0) bad++;
        check("t1_data", 32'(bad), 32'd0);
        check("t1_we_cycles", 32'(we_cnt - w0), 32'd8);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1_done_after_last", 32'(done_cyc - last_wr_cyc), 32'd1);
        check("t1_done_latency", 32'(done_cyc - accept_cyc), 32'd10);
        check("t1_ready", 32'(bus.cmd_ready), 32'd1);

        // Clipping at the bottom-right corner
        exp2 = '{76478, 76479, 76798, 76799};
        base = wr_addr.size(); d0 = done_cnt;
        send(9'd318, 8'd238, 9'd5, 8'd5, 8'h03);
        run(10);
        check("t2_nwr", 32'(wr_addr.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (base + i < wr_addr.size()) check("t2_addr", 32'(wr_addr[base+i]), 32'(exp2[i]));
        check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Rejected commands: w==0, then x0==FB_W
        for (int k = 0; k < 2; k++) begin
            base = wr_addr.size(); d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
            if (k == 0) send(9'd10, 8'd10, 9'd0, 8'd5, 8'h11);
            else        send(9'd320, 8'd0, 9'd4, 8'd1, 8'h11);
            run(4);
            check("t3_err_cnt", 32'(err_cnt - e0), 32'd1);
            check("t3_err_latency", 32'(err_cyc - accept_cyc), 32'd2);
            check("t3_no_we", 32'(we_cnt - w0), 32'd0);
            check("t3_no_done", 32'(done_cnt - d0), 32'd0);
            check("t3_nwr", 32'(wr_addr.size() - base), 32'd0);
            check("t3_ready", 32'(bus.cmd_ready), 32'd1);
        end

        // Back-pressure on a 3x1 fill at (7,1)
        bp = 6'b010011;
        base = wr_addr.size(); d0 = done_cnt; e0 = stall_err;
        bus.gmem_wready = 1'b0;
        send(9'd7, 8'd1, 9'd3, 8'd1, 8'h5A);
        cyc();
        for (int i = 0; i < 6; i++) begin
            bus.gmem_wready = bp[i];
            cyc();
        end
        bus.gmem_wready = 1'b1;
        run(3);
        check("t4_nwr", 32'(wr_addr.size() - base), 32'd3);
        for (int i = 0; i < 3; i++)
            if (base + i < wr_addr.size()) check("t4_addr", 32'(wr_addr[base+i]), 32'(327 + i));
        check("t4_stall_stable", 32'(stall_err - e0), 32'd0);
        check("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Abort after the 20th accepted write of a 100x1 fill at (50,100)
        base = wr_addr.size(); d0 = done_cnt;
        send(9'd50, 8'd100, 9'd100, 8'd1, 8'h77);
        for (int k = 0; k < 200 && (wr_addr.size() - base) < 19; k++) cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        check("t5_we_low", 32'(bus.gmem_we), 32'd0);
        check("t5_busy_low", 32'(bus.busy), 32'd0);
        check("t5_nwr", 32'(wr_addr.size() - base), 32'd20);
        if (wr_addr.size() - base >= 20) begin
            check("t5_first", 32'(wr_addr[base]), 32'd32050);
            check("t5_last", 32'(wr_addr[base+19]), 32'd32069);
        end
        cyc();
        send(9'd3, 8'd2, 9'd2, 8'd1, 8'h42);
        run(6);
        check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t5_nwr_after", 32'(wr_addr.size() - base), 32'd22);
        if (wr_addr.size() - base >= 22) begin
            check("t5_new_addr0", 32'(wr_addr[base+20]), 32'd643);
            check("t5_new_addr1", 32'(wr_addr[base+21]), 32'd644);
        end

        // abort ignored in IDLE alongside a command; single last pixel
        base = wr_addr.size(); d0 = done_cnt;
        bus.abort = 1'b1;
        send(9'd319, 8'd239, 9'd1, 8'd1, 8'hFF);
        bus.abort = 1'b0;
        run(5);
        check("t6_nwr", 32'(wr_addr.size() - base), 32'd1);
        if (wr_addr.size() > base) check("t6_addr", 32'(wr_addr[base]), 32'd76799);
        check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Full screen
        base = wr_addr.size(); d0 = done_cnt; w0 = we_cnt;
        send(9'd0, 8'd0, 9'd320, 8'd240, 8'h1C);
        run(76810);
        check("t7_nwr", 32'(wr_addr.size() - base), 32'd76800);
        bad = 0;
        for (int i = base; i < wr_addr.size(); i++) if (wr_addr[i] != i - base) bad++;
        check("t7_consecutive", 32'(bad), 32'd0);
        check("t7_we_cycles", 32'(we_cnt - w0), 32'd76800);
        check("t7_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t7_done_latency", 32'(done_cyc - accept_cyc), 32'd76802);

        // Reset mid-fill
        d0 = done_cnt;
        send(9'd0, 8'd0, 9'd50, 8'd3, 8'h55);
        run(20);
        rst = 1'b1;
        cyc();
        check_reset_outs("t8_rst");
        rst = 1'b0;
        base = wr_addr.size();
        run(10);
        check("t8_no_writes", 32'(wr_addr.size() - base), 32'd0);
        check("t8_no_done", 32'(done_cnt - d0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
